// File: rtl/pdemux_reg.sv
`default_nettype none
// ============================================================================
// Module   : pdemux_reg
// Brief    : Registered one-hot demultiplexer with per-lane valid/ready
//            holding registers, delivery counters and a sticky select error.
// Revision : 1.0
// ============================================================================
module pdemux_reg #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   in_data,
    input  logic [2:0]     s,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   out_a,
    output logic [3*W-1:0] out_b,
    output logic [3:0]     out_valid,
    input  logic [3:0]     out_ready,
    output logic [31:0]    cnt,
    output logic           sel_err,
    input  logic           err_clr
);

    localparam int C_LANES = 4;

    logic [1:0]   w_lane;
    logic         w_sel_ok;
    logic         w_accept;
    logic [3:0]   w_load;
    logic [3:0]   w_drain;

    logic [W-1:0] r_data [C_LANES];
    logic [3:0]   r_valid;
    logic [7:0]   r_cnt  [C_LANES];
    logic         r_sel_err;

    // Same decode as the one-hot priority mux: anything not one-hot lands on lane 0.
    always_comb begin
        w_lane   = 2'd0;
        w_sel_ok = 1'b1;
        case (s)
            3'b000:  w_lane = 2'd0;
            3'b001:  w_lane = 2'd1;
            3'b010:  w_lane = 2'd2;
            3'b100:  w_lane = 2'd3;
            default: w_sel_ok = 1'b0;
        endcase
    end

    assign in_ready = !r_valid[w_lane] || out_ready[w_lane];
    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_valid & out_ready;

    always_comb begin
        w_load         = 4'b0000;
        w_load[w_lane] = w_accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 4'b0000;
            for (int i = 0; i < C_LANES; i++) begin
                r_data[i] <= '0;
                r_cnt[i]  <= 8'd0;
            end
        end else begin
            for (int i = 0; i < C_LANES; i++) begin
                // A refill on a draining lane keeps valid high: no bubble.
                if (w_load[i]) begin
                    r_data[i]  <= in_data;
                    r_valid[i] <= 1'b1;
                end else if (w_drain[i]) begin
                    r_valid[i] <= 1'b0;
                end
                if (w_drain[i]) begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && !w_sel_ok) begin
            r_sel_err <= 1'b1;
        end else if (err_clr) begin
            r_sel_err <= 1'b0;
        end
    end

    assign out_a     = r_data[0];
    assign out_valid = r_valid;
    assign sel_err   = r_sel_err;

    generate
        for (genvar g = 0; g < C_LANES; g++) begin : g_cnt
            assign cnt[8*g +: 8] = r_cnt[g];
        end
        for (genvar g = 1; g < C_LANES; g++) begin : g_out_b
            assign out_b[W*(g-1) +: W] = r_data[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pdemux_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdemux_reg
// Brief    : Directed vector table plus hand-written corner sequences for
//            pdemux_reg (default W = 4).
// Revision : 1.0
// ============================================================================
module tb_pdemux_reg;

    logic        clk;
    logic        rst_n;
    logic [3:0]  in_data;
    logic [2:0]  s;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  out_a;
    logic [11:0] out_b;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] cnt;
    logic        sel_err;
    logic        err_clr;

    int n_pass;
    int n_total;

    pdemux_reg #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .s         (s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt       (cnt),
        .sel_err   (sel_err),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  d;
        logic [2:0]  s;
        logic        v;
        logic [3:0]  ordy;
        logic        clr;
        logic        rdy;
        logic [3:0]  valid;
        logic [3:0]  a;
        logic [11:0] b;
        logic        err;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic [3:0] d, input logic [2:0] ss, input logic v,
                                input logic [3:0] ordy, input logic clr, input logic rdy,
                                input logic [3:0] valid, input logic [3:0] a,
                                input logic [11:0] b, input logic err, input logic [31:0] c);
        vec_t r;
        r.d = d; r.s = ss; r.v = v; r.ordy = ordy; r.clr = clr;
        r.rdy = rdy; r.valid = valid; r.a = a; r.b = b; r.err = err; r.cnt = c;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic [3:0] d, input logic [2:0] ss, input logic v,
                         input logic [3:0] ordy, input logic clr);
        in_data   = d;
        s         = ss;
        in_valid  = v;
        out_ready = ordy;
        err_clr   = clr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(4'h0, 3'b000, 1'b0, 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b1;
        drive(4'h0, 3'b000, 1'b0, 4'b0000, 1'b0);

        //            d    s       v  ordy     clr rdy valid    a     b        err  cnt
        tbl[0]  = mk(4'hA, 3'b001, 1, 4'b1111, 0,  1,  4'b0010, 4'h0, 12'h00A, 0, 32'h0000_0000);
        tbl[1]  = mk(4'h0, 3'b000, 0, 4'b1111, 0,  1,  4'b0000, 4'h0, 12'h00A, 0, 32'h0000_0100);
        tbl[2]  = mk(4'h1, 3'b000, 1, 4'b0000, 0,  1,  4'b0001, 4'h1, 12'h00A, 0, 32'h0000_0100);
        tbl[3]  = mk(4'h2, 3'b001, 1, 4'b0000, 0,  1,  4'b0011, 4'h1, 12'h002, 0, 32'h0000_0100);
        tbl[4]  = mk(4'h3, 3'b010, 1, 4'b0000, 0,  1,  4'b0111, 4'h1, 12'h032, 0, 32'h0000_0100);
        tbl[5]  = mk(4'h4, 3'b100, 1, 4'b0000, 0,  1,  4'b1111, 4'h1, 12'h432, 0, 32'h0000_0100);
        tbl[6]  = mk(4'h5, 3'b010, 1, 4'b0000, 0,  0,  4'b1111, 4'h1, 12'h432, 0, 32'h0000_0100);
        tbl[7]  = mk(4'h5, 3'b010, 1, 4'b0100, 0,  1,  4'b1111, 4'h1, 12'h452, 0, 32'h0001_0100);
        tbl[8]  = mk(4'h6, 3'b100, 0, 4'b0001, 0,  0,  4'b1110, 4'h1, 12'h452, 0, 32'h0001_0101);
        tbl[9]  = mk(4'h7, 3'b000, 1, 4'b0000, 0,  1,  4'b1111, 4'h7, 12'h452, 0, 32'h0001_0101);
        tbl[10] = mk(4'h5, 3'b011, 1, 4'b0001, 0,  1,  4'b1111, 4'h5, 12'h452, 1, 32'h0001_0102);
        tbl[11] = mk(4'h8, 3'b111, 1, 4'b0001, 1,  1,  4'b1111, 4'h8, 12'h452, 1, 32'h0001_0103);
        tbl[12] = mk(4'h0, 3'b000, 0, 4'b1111, 1,  1,  4'b0000, 4'h8, 12'h452, 0, 32'h0102_0204);
        tbl[13] = mk(4'h9, 3'b110, 0, 4'b0000, 0,  1,  4'b0000, 4'h8, 12'h452, 0, 32'h0102_0204);

        // Asynchronous reset: outputs clear before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("reset_valid",   {28'd0, out_valid}, 32'h0);
        chk("reset_a",       {28'd0, out_a},     32'h0);
        chk("reset_b",       {20'd0, out_b},     32'h0);
        chk("reset_cnt",     cnt,                32'h0);
        chk("reset_err",     {31'd0, sel_err},   32'h0);
        chk("reset_ready",   {31'd0, in_ready},  32'h1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            drive(tbl[i].d, tbl[i].s, tbl[i].v, tbl[i].ordy, tbl[i].clr);
            #1;
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].rdy});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), {28'd0, out_valid}, {28'd0, tbl[i].valid});
            chk($sformatf("v%0d_out_a", i),     {28'd0, out_a},     {28'd0, tbl[i].a});
            chk($sformatf("v%0d_out_b", i),     {20'd0, out_b},     {20'd0, tbl[i].b});
            chk($sformatf("v%0d_sel_err", i),   {31'd0, sel_err},   {31'd0, tbl[i].err});
            chk($sformatf("v%0d_cnt", i),       cnt,                tbl[i].cnt);
        end

        // Back-to-back stream of 300 words into lane 3 with its consumer always ready.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic [31:0] iv;
            iv = i;
            @(negedge clk);
            drive(iv[3:0], 3'b100, 1'b1, 4'b1000, 1'b0);
            #1;
            chk($sformatf("stream%0d_ready", i), {31'd0, in_ready}, 32'h1);
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d_data", i), {28'd0, out_b[11:8]}, {28'd0, iv[3:0]});
            chk($sformatf("stream%0d_valid", i), {28'd0, out_valid}, 32'h8);
        end
        @(negedge clk);
        drive(4'h0, 3'b000, 1'b0, 4'b1000, 1'b0);
        @(posedge clk);
        #1;
        chk("stream_cnt3", {24'd0, cnt[31:24]}, 32'd44);
        chk("stream_cnt_other", {8'd0, cnt[23:0]}, 32'd0);
        chk("stream_drained", {28'd0, out_valid}, 32'h0);

        // Reset mid-transfer with lanes 0 and 2 holding stalled words.
        do_reset();
        @(negedge clk);
        drive(4'h6, 3'b011, 1'b1, 4'b0000, 1'b0);
        @(negedge clk);
        drive(4'hC, 3'b010, 1'b1, 4'b0000, 1'b0);
        @(negedge clk);
        drive(4'h0, 3'b000, 1'b0, 4'b0000, 1'b0);
        #1;
        chk("mid_filled_valid", {28'd0, out_valid}, 32'h5);
        chk("mid_filled_err",   {31'd0, sel_err},   32'h1);
        chk("mid_stall_ready",  {31'd0, in_ready},  32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {28'd0, out_valid}, 32'h0);
        chk("mid_rst_cnt",   cnt,                32'h0);
        chk("mid_rst_a",     {28'd0, out_a},     32'h0);
        chk("mid_rst_b",     {20'd0, out_b},     32'h0);
        chk("mid_rst_err",   {31'd0, sel_err},   32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [31:0] kv;
            kv = k;
            s = kv[2:0];
            #1;
            chk($sformatf("post_rst_ready_s%0d", k), {31'd0, in_ready}, 32'h1);
        end
        drive(4'h0, 3'b000, 1'b0, 4'b1111, 1'b0);
        @(posedge clk);
        #1;
        chk("post_rst_no_count", cnt, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
